fetch_unit: RTL and testbench

//  Instruction-fetch front end of the pipelined RV32 cpu. Owns the fetch PC.

---
 rtl/fetch_unit.sv | 111 +++++++++++
 tb/tb_fetch_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues word requests to a
// variable-latency imem and queues in-order {pc, inst} pairs for IF/ID.
module fetch_unit #(
   parameter int          DEPTH    = 4,
   parameter int          MAX_OUT  = 2,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        im_req,
   output logic [31:0] im_addr,
   input  logic        im_gnt,
   input  logic        im_rvalid,
   input  logic [31:0] im_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   input  logic        id_ready
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int OW = $clog2(MAX_OUT + 1);

   logic [31:0]   fetch_pc;
   logic [31:0]   resp_pc;
   logic [OW-1:0] live_cnt;
   logic [OW-1:0] drop_cnt;
   logic [CW-1:0] count;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [31:0]   pc_q   [DEPTH];
   logic [31:0]   inst_q [DEPTH];

   logic [31:0] occupied;
   logic [31:0] outstanding;
   logic [31:0] redirect_aligned;
   logic        grant;
   logic        rsp_any;
   logic        push;
   logic        drop;
   logic        pop;

   // Credit rule: a request is only issued when its response is sure to
   // find a free queue slot, so the queue can never overflow.
   always_comb begin
      occupied         = 32'(count) + 32'(live_cnt);
      outstanding      = 32'(live_cnt) + 32'(drop_cnt);
      redirect_aligned = redirect_pc & ~32'h3;
      im_req           = !rst && !redirect_valid && (occupied < 32'(DEPTH))
                         && (outstanding < 32'(MAX_OUT));
      im_addr          = fetch_pc;
      grant            = im_req && im_gnt;
      rsp_any          = im_rvalid && (outstanding != 32'd0);
      drop             = rsp_any && (drop_cnt != '0);
      push             = !rst && rsp_any && (drop_cnt == '0) && !redirect_valid;
      if_valid         = !rst && (count != '0);
      pop              = if_valid && id_ready && !redirect_valid;
      if_pc            = if_valid ? pc_q[rd_ptr]   : 32'h0;
      if_inst          = if_valid ? inst_q[rd_ptr] : 32'h0;
   end

   // A redirect squashes every live request; their responses still arrive
   // and are absorbed by drop_cnt before any new word is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc <= RESET_PC & ~32'h3;
         resp_pc  <= RESET_PC & ~32'h3;
         live_cnt <= '0;
         drop_cnt <= '0;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else if (redirect_valid) begin
         fetch_pc <= redirect_aligned;
         resp_pc  <= redirect_aligned;
         drop_cnt <= drop_cnt + live_cnt - OW'(rsp_any);
         live_cnt <= '0;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else begin
         if (grant)
            fetch_pc <= fetch_pc + 32'd4;
         if (push) begin
            resp_pc <= resp_pc + 32'd4;
            wr_ptr  <= wr_ptr + AW'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (drop)
            drop_cnt <= drop_cnt - OW'(1);
         live_cnt <= live_cnt + OW'(grant) - OW'(push);
         count    <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_q[wr_ptr]   <= resp_pc;
         inst_q[wr_ptr] <= im_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && im_rvalid)
         assert (outstanding != 32'd0)
         else $error("fetch_unit: im_rvalid with no request in flight");
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order imem model plus a queue-level reference
// checked every cycle, and directed cases with literal expectations.
module tb_fetch_unit;
   localparam int DEPTH   = 4;
   localparam int MAX_OUT = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        im_req;
   logic [31:0] im_addr;
   logic        im_gnt = 1'b0;
   logic        im_rvalid = 1'b0;
   logic [31:0] im_rdata = 32'h0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        id_ready = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;
   int lat_min  = 1;
   int lat_max  = 1;
   int gnt_pct  = 100;
   int cyc      = 0;

   typedef struct {
      logic [31:0] addr;
      int          due;
      bit          live;
   } req_t;

   req_t        pend[$];
   logic [31:0] mq[$];
   logic [31:0] next_issue;

   fetch_unit #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst),
      .im_req(im_req), .im_addr(im_addr), .im_gnt(im_gnt),
      .im_rvalid(im_rvalid), .im_rdata(im_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
      .id_ready(id_ready)
   );

   initial forever #5 clk = ~clk;

   function automatic logic [31:0] memword(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input bit r, input bit rv, input logic [31:0] rpc, input bit rdy);
      @(posedge clk);
      #1;
      rst            = r;
      redirect_valid = rv;
      redirect_pc    = rpc;
      id_ready       = rdy;
   endtask

   task automatic resetDut(input bit rdy);
      applyStimulus(1'b1, 1'b0, 32'h0, rdy);
      applyStimulus(1'b1, 1'b0, 32'h0, rdy);
      applyStimulus(1'b0, 1'b0, 32'h0, rdy);
   endtask

   task automatic waitPop(input string name, input logic [31:0] exp);
      int n;
      n = 0;
      @(negedge clk);
      while (!(if_valid && id_ready) && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (if_valid && id_ready)
         checkOutput(name, if_pc, exp);
      else
         checkOutput({name, "_timeout"}, {31'b0, if_valid}, 32'h1);
   endtask

   // Memory side plus reference: every granted address is remembered in
   // order; live ones become queue entries, squashed ones vanish.
   initial begin : imem_model
      req_t e;
      int   live_n;
      bit   exp_req;
      next_issue = 32'h0;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (pend.size() != 0 && pend[0].due <= cyc) begin
            im_rvalid = 1'b1;
            im_rdata  = memword(pend[0].addr);
         end else begin
            im_rvalid = 1'b0;
            im_rdata  = 32'hDEAD_BEEF;
         end
         im_gnt = ($urandom_range(99) < gnt_pct);
         @(negedge clk);
         if (rst) begin
            checkOutput("rst_if_valid", {31'b0, if_valid}, 32'h0);
            checkOutput("rst_if_pc", if_pc, 32'h0);
            checkOutput("rst_if_inst", if_inst, 32'h0);
            checkOutput("rst_im_req", {31'b0, im_req}, 32'h0);
            pend.delete();
            mq.delete();
            next_issue = 32'h0;
         end else begin
            live_n = 0;
            for (int i = 0; i < pend.size(); i++)
               if (pend[i].live) live_n++;
            exp_req = !redirect_valid && (mq.size() + live_n < DEPTH) && (pend.size() < MAX_OUT);
            checkOutput("im_req", {31'b0, im_req}, {31'b0, exp_req});
            if (exp_req && im_req)
               checkOutput("im_addr", im_addr, next_issue);
            checkOutput("if_valid", {31'b0, if_valid}, (mq.size() != 0) ? 32'h1 : 32'h0);
            checkOutput("if_pc", if_pc, (mq.size() != 0) ? mq[0] : 32'h0);
            checkOutput("if_inst", if_inst, (mq.size() != 0) ? memword(mq[0]) : 32'h0);
            if (redirect_valid) begin
               if (im_rvalid && pend.size() != 0)
                  void'(pend.pop_front());
               for (int i = 0; i < pend.size(); i++) begin
                  e         = pend[i];
                  e.live    = 1'b0;
                  pend[i]   = e;
               end
               mq.delete();
               next_issue = redirect_pc & ~32'h3;
            end else begin
               if (mq.size() != 0 && id_ready)
                  void'(mq.pop_front());
               if (im_rvalid && pend.size() != 0) begin
                  e = pend.pop_front();
                  if (e.live)
                     mq.push_back(e.addr);
               end
               if (im_req && im_gnt) begin
                  e.addr = next_issue;
                  e.due  = cyc + int'($urandom_range(lat_max, lat_min));
                  e.live = 1'b1;
                  pend.push_back(e);
                  next_issue = next_issue + 32'd4;
               end
            end
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      int grants;
      int unstable;
      int pops;
      logic [31:0] tgt;
      bit rv;

      // Latency 1, consumer always ready: sequential stream from reset.
      lat_min = 1; lat_max = 1; gnt_pct = 100;
      resetDut(1'b1);
      @(negedge clk);
      checkOutput("t1_req", {31'b0, im_req}, 32'h1);
      checkOutput("t1_addr0", im_addr, 32'h0);
      @(negedge clk);
      checkOutput("t1_not_yet_valid", {31'b0, if_valid}, 32'h0);
      checkOutput("t1_addr1", im_addr, 32'h4);
      @(negedge clk);
      checkOutput("t1_first_valid", {31'b0, if_valid}, 32'h1);
      checkOutput("t1_pc0", if_pc, 32'h0);
      checkOutput("t1_inst0", if_inst, 32'h1357_9BDF);
      @(negedge clk);
      checkOutput("t1_pc1", if_pc, 32'h4);
      @(negedge clk);
      checkOutput("t1_pc2", if_pc, 32'h8);
      @(negedge clk);
      checkOutput("t1_pc3", if_pc, 32'hC);

      // Stall for 10 cycles: queue fills to DEPTH, head holds.
      resetDut(1'b0);
      grants = 0;
      unstable = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (im_req && im_gnt) grants++;
         if (i >= 2 && (!if_valid || if_pc != 32'h0)) unstable++;
      end
      checkOutput("t2_grants", 32'(grants), 32'd4);
      checkOutput("t2_unstable", 32'(unstable), 32'd0);
      checkOutput("t2_hold_pc", if_pc, 32'h0);
      checkOutput("t2_hold_inst", if_inst, 32'h1357_9BDF);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      for (int k = 0; k < 6; k++)
         waitPop("t2_pop", 32'(k * 4));

      // Latency 3, redirect with two live requests outstanding.
      lat_min = 3; lat_max = 3;
      resetDut(1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      applyStimulus(1'b0, 1'b1, 32'h103, 1'b1);
      @(negedge clk);
      checkOutput("t3_req_in_redirect", {31'b0, im_req}, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      checkOutput("t3_addr_after", im_addr, 32'h100);
      waitPop("t3_pop0", 32'h100);
      waitPop("t3_pop1", 32'h104);

      // Redirect coinciding with a response and a pop.
      lat_min = 1; lat_max = 1;
      resetDut(1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      applyStimulus(1'b0, 1'b1, 32'h200, 1'b1);
      @(negedge clk);
      checkOutput("t4_head_valid", {31'b0, if_valid}, 32'h1);
      checkOutput("t4_head_pc", if_pc, 32'h4);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      checkOutput("t4_flushed", {31'b0, if_valid}, 32'h0);
      checkOutput("t4_addr", im_addr, 32'h200);
      waitPop("t4_pop0", 32'h200);
      waitPop("t4_pop1", 32'h204);

      // Address wrap at the top of memory.
      applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      waitPop("t5_pop_top", 32'hFFFF_FFFC);
      waitPop("t5_pop_wrap", 32'h0000_0000);
      waitPop("t5_pop_next", 32'h0000_0004);

      // Random grant, latency, stalls, redirects and one mid-run reset.
      lat_min = 1; lat_max = 4; gnt_pct = 60;
      pops = 0;
      for (int i = 0; i < 600; i++) begin
         tgt = $urandom;
         rv  = ($urandom_range(15) == 0);
         applyStimulus(i == 300, rv, tgt, $urandom_range(9) < 7);
         @(negedge clk);
         if (!rst && if_valid && id_ready && !redirect_valid) pops++;
      end
      lat_min = 1; lat_max = 1; gnt_pct = 100;
      for (int i = 0; i < 20; i++)
         applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      checkOutput("t6_progress", (pops > 50) ? 32'h1 : 32'h0, 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
